regfile_wr_arbiter: RTL and testbench
=====================================

REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port start_init, input, 1 bit: request to re-clear the register file.
REQ-004 SHALL have port req_valid, input, 3 bits: bit i = requester i has a write pending.
REQ-005 SHALL have ports req_addr0/req_addr1/req_addr2, input, 5 bits each: target register per requester.
REQ-006 SHALL have ports req_data0/req_data1/req_data2, input, 32 bits each: write data per requester.
REQ-007 SHALL have port req_ready, output, 3 bits: bit i = requester i granted this cycle (combinational).
REQ-008 SHALL have port rf_we, output, 1 bit: registered write enable to register file.
REQ-009 SHALL have port rf_waddr, output, 5 bits: registered write address.
REQ-010 SHALL have port rf_wdata, output, 32 bits: registered write data.
REQ-011 SHALL have port init_done, output, 1 bit: high when clear sequence finished and arbitration active.

Function
REQ-012 SHALL implement two states: INIT (sequential clear) and ARB (round-robin arbitration).
REQ-013 SHALL, in INIT, drive rf_we=1, rf_waddr=init count, rf_wdata=0 on each edge, count 0..31, one address per cycle.
REQ-014 SHALL move INIT->ARB on the edge that registers address 31, setting init_done=1 on that same edge.
REQ-015 SHALL hold req_ready=3'b000 throughout INIT; req_valid ignored.
REQ-016 SHALL, in ARB with start_init=0, assert exactly one req_ready bit: first set req_valid bit searched from rr pointer upward, modulo 3; none if req_valid=0.
REQ-017 SHALL define a transfer as req_valid[i] & req_ready[i] in a cycle.
REQ-018 SHALL, on the edge ending a transfer, register rf_we=1, rf_waddr=req_addrI, rf_wdata=req_dataI (one-cycle latency).
REQ-019 SHALL, on the same edge, set rr pointer = (granted index + 1) mod 3 (2 wraps to 0).
REQ-020 SHALL, on any ARB edge without transfer, register rf_we=0 and hold rf_waddr/rf_wdata.
REQ-021 SHALL sustain one transfer per cycle under continuous requests (no bubble cycles).
REQ-022 SHALL pass address 0 unmodified; no address filtering.
REQ-023 SHALL, when start_init=1 in ARB, drive req_ready=0 that cycle, register rf_we=0, clear init_done, zero init count, enter INIT next edge.
REQ-024 SHALL ignore start_init while in INIT (sequence not restarted).
REQ-025 SHALL leave rr pointer unchanged across an INIT sequence caused by start_init.

Reset
REQ-026 SHALL, on any edge with reset=1, set state=INIT, init count=0, rr pointer=0, rf_we=0, rf_waddr=0, rf_wdata=0, init_done=0; req_ready=0 consequently.
REQ-027 SHALL give reset priority over start_init and transfers, including mid-INIT (count restarts at 0).
REQ-028 SHALL issue first clear write (rf_we=1, rf_waddr=0) on first edge after reset deasserts; init_done rises 32 edges after reset release.

Verification
REQ-029 Reset 2 cycles, release -> rf_we=1 for 32 consecutive edges, rf_waddr 0..31, rf_wdata=0; then rf_we=0, init_done=1.
REQ-030 After init, req_valid=3'b111 held, addr0/1/2=5/6/7, data0/1/2=32'd1/2/3 for 6 cycles -> req_ready 001,010,100,001,010,100; rf_waddr 5,6,7,5,6,7, rf_we=1 each edge.
REQ-031 After grant to 2, req_valid=3'b001, addr0=3, data0=32'hDEAD_BEEF -> req_ready=001 same cycle; next edge rf_we=1, rf_waddr=3, rf_wdata=32'hDEAD_BEEF; rr pointer=1.
REQ-032 req_valid=0 for 3 cycles after write -> rf_we=0, rf_waddr/rf_wdata hold last values.
REQ-033 start_init=1 with req_valid=3'b010 in ARB -> req_ready=000 that cycle; init_done falls; 32 clear writes 0..31; requester 1 served first cycle after init_done rises.
REQ-034 reset=1 asserted at 10th INIT write -> rf_we=0 next edge; after release clear restarts at rf_waddr=0.

Source files
------------

// File: rtl/regfile_wr_arbiter_if.sv
// rtl/regfile_wr_arbiter_if.sv - requester and register-file write bundle for the write arbiter
interface regfile_wr_arbiter_if;
    logic        start_init;
    logic [2:0]  req_valid;
    logic [4:0]  req_addr0;
    logic [4:0]  req_addr1;
    logic [4:0]  req_addr2;
    logic [31:0] req_data0;
    logic [31:0] req_data1;
    logic [31:0] req_data2;
    logic [2:0]  req_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        init_done;

    // requester / control side
    modport master (
        output start_init,
        output req_valid,
        output req_addr0,
        output req_addr1,
        output req_addr2,
        output req_data0,
        output req_data1,
        output req_data2,
        input  req_ready,
        input  rf_we,
        input  rf_waddr,
        input  rf_wdata,
        input  init_done
    );

    // arbiter side
    modport slave (
        input  start_init,
        input  req_valid,
        input  req_addr0,
        input  req_addr1,
        input  req_addr2,
        input  req_data0,
        input  req_data1,
        input  req_data2,
        output req_ready,
        output rf_we,
        output rf_waddr,
        output rf_wdata,
        output init_done
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - clears a 32-entry register file, then round-robins three write requesters onto one port
module regfile_wr_arbiter (
    input  logic                 clk,
    input  logic                 reset,
    regfile_wr_arbiter_if.slave  wr
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_ARB  = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [4:0]  init_cnt;
    logic [1:0]  rr_ptr;
    logic        init_done_q;

    logic        rf_we_q;
    logic [4:0]  rf_waddr_q;
    logic [31:0] rf_wdata_q;

    logic [2:0]  rr_grant;
    logic [2:0]  grant;
    logic        xfer;
    logic [4:0]  sel_addr;
    logic [31:0] sel_data;
    logic [1:0]  rr_next;

    // state register; reset always lands in the clear sequence
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // next state: clear runs to address 31, start_init only honoured while arbitrating
    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT: begin
                if (init_cnt == 5'd31) begin
                    state_nxt = ST_ARB;
                end
            end
            ST_ARB: begin
                if (wr.start_init) begin
                    state_nxt = ST_INIT;
                end
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    // round-robin pick: first pending requester at or above rr_ptr, wrapping modulo 3
    always_comb begin
        rr_grant = 3'b000;
        case (rr_ptr)
            2'd0: begin
                if      (wr.req_valid[0]) rr_grant = 3'b001;
                else if (wr.req_valid[1]) rr_grant = 3'b010;
                else if (wr.req_valid[2]) rr_grant = 3'b100;
            end
            2'd1: begin
                if      (wr.req_valid[1]) rr_grant = 3'b010;
                else if (wr.req_valid[2]) rr_grant = 3'b100;
                else if (wr.req_valid[0]) rr_grant = 3'b001;
            end
            default: begin
                if      (wr.req_valid[2]) rr_grant = 3'b100;
                else if (wr.req_valid[0]) rr_grant = 3'b001;
                else if (wr.req_valid[1]) rr_grant = 3'b010;
            end
        endcase
    end

    // grants are suppressed while clearing, on a re-init request and under reset
    always_comb begin
        grant = 3'b000;
        if (state == ST_ARB && !wr.start_init && !reset) begin
            grant = rr_grant;
        end
    end

    // a grant is only ever given to a valid requester, so any grant is a transfer
    always_comb begin
        xfer     = |grant;
        sel_addr = wr.req_addr0;
        sel_data = wr.req_data0;
        rr_next  = 2'd1;
        if (grant[1]) begin
            sel_addr = wr.req_addr1;
            sel_data = wr.req_data1;
            rr_next  = 2'd2;
        end else if (grant[2]) begin
            sel_addr = wr.req_addr2;
            sel_data = wr.req_data2;
            rr_next  = 2'd0;
        end
    end

    // write port, clear counter, rotation pointer and init_done
    always_ff @(posedge clk) begin
        if (reset) begin
            init_cnt    <= 5'd0;
            rr_ptr      <= 2'd0;
            init_done_q <= 1'b0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= 5'd0;
            rf_wdata_q  <= 32'd0;
        end else begin
            case (state)
                ST_INIT: begin
                    rf_we_q    <= 1'b1;
                    rf_waddr_q <= init_cnt;
                    rf_wdata_q <= 32'd0;
                    init_cnt   <= init_cnt + 5'd1;
                    if (init_cnt == 5'd31) begin
                        init_done_q <= 1'b1;
                    end
                end
                ST_ARB: begin
                    if (wr.start_init) begin
                        rf_we_q     <= 1'b0;
                        init_done_q <= 1'b0;
                        init_cnt    <= 5'd0;
                    end else if (xfer) begin
                        rf_we_q    <= 1'b1;
                        rf_waddr_q <= sel_addr;
                        rf_wdata_q <= sel_data;
                        rr_ptr     <= rr_next;
                    end else begin
                        rf_we_q <= 1'b0;
                    end
                end
                default: begin
                    rf_we_q <= 1'b0;
                end
            endcase
        end
    end

    assign wr.req_ready = grant;
    assign wr.rf_we     = rf_we_q;
    assign wr.rf_waddr  = rf_waddr_q;
    assign wr.rf_wdata  = rf_wdata_q;
    assign wr.init_done = init_done_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb/tb_regfile_wr_arbiter.sv - self-checking bench for regfile_wr_arbiter
module tb_regfile_wr_arbiter;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    regfile_wr_arbiter_if bus ();

    regfile_wr_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .wr    (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // reference model: high-level view of the arbiter
    bit          m_init;
    int          m_cnt;
    int          m_rr;
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic        m_done;

    logic [31:0] model_mem [32];
    logic [31:0] dut_mem   [32];

    typedef struct {
        logic        rst;
        logic        si;
        logic [2:0]  v;
        logic [4:0]  a0, a1, a2;
        logic [31:0] d0, d1, d2;
        logic [2:0]  e_ready;
        logic        e_we;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        logic        e_done;
    } vec_t;

    vec_t vecs [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic si, input logic [2:0] v,
                         input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                         input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
        reset          = rst;
        bus.start_init = si;
        bus.req_valid  = v;
        bus.req_addr0  = a0;
        bus.req_addr1  = a1;
        bus.req_addr2  = a2;
        bus.req_data0  = d0;
        bus.req_data1  = d1;
        bus.req_data2  = d2;
    endtask

    function automatic logic [2:0] m_ready();
        if (reset || m_init || bus.start_init) return 3'b000;
        for (int k = 0; k < 3; k++) begin
            int i;
            i = (m_rr + k) % 3;
            if (bus.req_valid[i]) return 3'(1 << i);
        end
        return 3'b000;
    endfunction

    // one clock: check ready, advance model, clock, check registered outputs
    task automatic cycle();
        logic [2:0] er;
        int         g;
        #2;
        er = m_ready();
        chk("req_ready", bus.req_ready, er);
        g = -1;
        for (int k = 0; k < 3; k++) if (er[k]) g = k;
        if (reset) begin
            m_init = 1; m_cnt = 0; m_rr = 0;
            m_we = 0; m_waddr = 0; m_wdata = 0; m_done = 0;
        end else if (m_init) begin
            m_we = 1; m_waddr = 5'(m_cnt); m_wdata = 0;
            if (m_cnt == 31) begin
                m_init = 0;
                m_done = 1;
            end
            m_cnt = (m_cnt + 1) % 32;
        end else if (bus.start_init) begin
            m_we = 0; m_done = 0; m_cnt = 0; m_init = 1;
        end else if (g >= 0) begin
            m_we    = 1;
            m_waddr = (g == 0) ? bus.req_addr0 : (g == 1) ? bus.req_addr1 : bus.req_addr2;
            m_wdata = (g == 0) ? bus.req_data0 : (g == 1) ? bus.req_data1 : bus.req_data2;
            m_rr    = (g + 1) % 3;
        end else begin
            m_we = 0;
        end
        @(posedge clk);
        #1;
        if (bus.rf_we) dut_mem[bus.rf_waddr] = bus.rf_wdata;
        if (m_we)      model_mem[m_waddr]    = m_wdata;
        chk("rf_we",     bus.rf_we,     m_we);
        chk("rf_waddr",  bus.rf_waddr,  m_waddr);
        chk("rf_wdata",  bus.rf_wdata,  m_wdata);
        chk("init_done", bus.init_done, m_done);
    endtask

    task automatic apply(input vec_t r);
        drive(r.rst, r.si, r.v, r.a0, r.a1, r.a2, r.d0, r.d1, r.d2);
        #1;
        chk("vec_ready", bus.req_ready, r.e_ready);
        cycle();
        chk("vec_we",    bus.rf_we,     r.e_we);
        chk("vec_waddr", bus.rf_waddr,  r.e_waddr);
        chk("vec_wdata", bus.rf_wdata,  r.e_wdata);
        chk("vec_done",  bus.init_done, r.e_done);
    endtask

    task automatic add(input logic [2:0] v, input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [2:0] er, input logic ew, input logic [4:0] ea, input logic [31:0] ed);
        vec_t r;
        r.rst = 0; r.si = 0; r.v = v;
        r.a0 = a0; r.a1 = a1; r.a2 = a2;
        r.d0 = d0; r.d1 = d1; r.d2 = d2;
        r.e_ready = er; r.e_we = ew; r.e_waddr = ea; r.e_wdata = ed; r.e_done = 1'b1;
        vecs.push_back(r);
    endtask

    initial begin
        m_init = 1; m_cnt = 0; m_rr = 0;
        m_we = 0; m_waddr = 0; m_wdata = 0; m_done = 0;
        for (int i = 0; i < 32; i++) begin
            model_mem[i] = 32'hFFFF_FFFF;
            dut_mem[i]   = 32'hFFFF_FFFF;
        end

        // round-robin, single requester, idle hold, rotation after it, address 0
        for (int i = 0; i < 6; i++)
            add(3'b111, 5, 6, 7, 1, 2, 3, 3'(1 << (i % 3)), 1, 5'(5 + i % 3), 32'(1 + i % 3));
        add(3'b001, 3, 6, 7, 32'hDEAD_BEEF, 2, 3, 3'b001, 1, 3, 32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++)
            add(3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 3, 32'hDEAD_BEEF);
        add(3'b111, 5, 6, 7, 1, 2, 3, 3'b010, 1, 6, 2);
        add(3'b100, 5, 6, 0, 1, 2, 32'h55, 3'b100, 1, 0, 32'h55);
        add(3'b011, 4, 8, 0, 32'hA, 32'hB, 0, 3'b001, 1, 4, 32'hA);

        // reset for two cycles
        drive(1, 0, 3'b111, 1, 2, 3, 4, 5, 6);
        cycle();
        cycle();
        chk("rst_we",   bus.rf_we,     0);
        chk("rst_addr", bus.rf_waddr,  0);
        chk("rst_data", bus.rf_wdata,  0);
        chk("rst_done", bus.init_done, 0);
        chk("rst_rdy",  bus.req_ready, 0);

        // clear sequence after release, requests ignored
        drive(0, 1, 3'b111, 1, 2, 3, 4, 5, 6);
        for (int i = 0; i < 32; i++) begin
            cycle();
            chk("init_we",   bus.rf_we,     1);
            chk("init_addr", bus.rf_waddr,  i);
            chk("init_data", bus.rf_wdata,  0);
            chk("init_done", bus.init_done, (i == 31) ? 1 : 0);
        end
        drive(0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("post_init_we",   bus.rf_we,     0);
        chk("post_init_done", bus.init_done, 1);

        foreach (vecs[i]) apply(vecs[i]);

        // re-init request while requester 1 is pending
        drive(0, 1, 3'b010, 0, 9, 0, 0, 32'h99, 0);
        #1;
        chk("si_ready", bus.req_ready, 0);
        cycle();
        chk("si_we",   bus.rf_we,     0);
        chk("si_done", bus.init_done, 0);
        for (int i = 0; i < 32; i++) begin
            bus.start_init = (i % 5 == 0);
            cycle();
            chk("reinit_addr", bus.rf_waddr, i);
            chk("reinit_we",   bus.rf_we,    1);
        end
        chk("reinit_done", bus.init_done, 1);
        bus.start_init = 0;
        #1;
        chk("first_after_reinit", bus.req_ready, 3'b010);
        cycle();
        chk("served_addr", bus.rf_waddr, 9);
        chk("served_data", bus.rf_wdata, 32'h99);

        // reset in the middle of a clear sequence
        bus.start_init = 1;
        cycle();
        bus.start_init = 0;
        for (int i = 0; i < 9; i++) cycle();
        chk("mid_addr", bus.rf_waddr, 8);
        reset = 1;
        cycle();
        chk("midrst_we",   bus.rf_we,    0);
        chk("midrst_addr", bus.rf_waddr, 0);
        reset = 0;
        cycle();
        chk("restart_we",   bus.rf_we,    1);
        chk("restart_addr", bus.rf_waddr, 0);
        for (int i = 1; i < 32; i++) cycle();
        chk("restart_done", bus.init_done, 1);

        // randomized traffic against the model
        for (int n = 0; n < 2000; n++) begin
            drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 39) == 0), 3'($urandom_range(0, 7)),
                  5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom, $urandom);
            cycle();
        end

        for (int i = 0; i < 32; i++) chk("mem", dut_mem[i], model_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
